// File: rtl/time_keeper.sv
// Hours/minutes/seconds time keeper with 12/24-hour BCD display, per-field
// adjust on input rising edges, hold, and one-cycle rollover pulses.
module time_keeper #(
    parameter int FORMAT_24H    = 0,
    parameter int START_HOURS   = 12,
    parameter int START_MINUTES = 0,
    parameter int START_SECONDS = 0
) (
    input  logic        i_Clk_5MHz,
    input  logic        i_Reset,
    input  logic        i_Clk_1Hz_Pulse,
    input  logic        i_Hold,
    input  logic        i_Minutes_Inc,
    input  logic        i_Minutes_Dec,
    input  logic        i_Hours_Inc,
    input  logic        i_Hours_Dec,
    input  logic        i_Seconds_Clear,
    output logic [23:0] o_Time,
    output logic        o_PM,
    output logic        o_Minute_Tick,
    output logic        o_Hour_Tick,
    output logic        o_Day_Tick
);

    logic [5:0] r_Sec;
    logic [5:0] r_Min;
    logic [4:0] r_Hr;
    logic       r_Prev_Min_Inc, r_Prev_Min_Dec, r_Prev_Hr_Inc, r_Prev_Hr_Dec, r_Prev_Sec_Clr;
    logic       r_Minute_Tick, r_Hour_Tick, r_Day_Tick;

    logic w_Min_Inc, w_Min_Dec, w_Hr_Inc, w_Hr_Dec, w_Sec_Clr, w_Any_Adj;

    assign w_Min_Inc = i_Minutes_Inc   & ~r_Prev_Min_Inc;
    assign w_Min_Dec = i_Minutes_Dec   & ~r_Prev_Min_Dec;
    assign w_Hr_Inc  = i_Hours_Inc     & ~r_Prev_Hr_Inc;
    assign w_Hr_Dec  = i_Hours_Dec     & ~r_Prev_Hr_Dec;
    assign w_Sec_Clr = i_Seconds_Clear & ~r_Prev_Sec_Clr;
    assign w_Any_Adj = w_Min_Inc | w_Min_Dec | w_Hr_Inc | w_Hr_Dec | w_Sec_Clr;

    always_ff @(posedge i_Clk_5MHz) begin
        if (i_Reset) begin
            r_Sec          <= 6'(START_SECONDS);
            r_Min          <= 6'(START_MINUTES);
            r_Hr           <= 5'(START_HOURS);
            // Loaded high so a level already asserted during reset is not seen as an edge
            r_Prev_Min_Inc <= 1'b1;
            r_Prev_Min_Dec <= 1'b1;
            r_Prev_Hr_Inc  <= 1'b1;
            r_Prev_Hr_Dec  <= 1'b1;
            r_Prev_Sec_Clr <= 1'b1;
            r_Minute_Tick  <= 1'b0;
            r_Hour_Tick    <= 1'b0;
            r_Day_Tick     <= 1'b0;
        end else begin
            r_Prev_Min_Inc <= i_Minutes_Inc;
            r_Prev_Min_Dec <= i_Minutes_Dec;
            r_Prev_Hr_Inc  <= i_Hours_Inc;
            r_Prev_Hr_Dec  <= i_Hours_Dec;
            r_Prev_Sec_Clr <= i_Seconds_Clear;
            r_Minute_Tick  <= 1'b0;
            r_Hour_Tick    <= 1'b0;
            r_Day_Tick     <= 1'b0;
            if (w_Any_Adj) begin
                // Opposing edges on one field cancel; a coincident tick is dropped
                if (w_Min_Inc && !w_Min_Dec)
                    r_Min <= (r_Min == 6'd59) ? 6'd0 : r_Min + 6'd1;
                else if (w_Min_Dec && !w_Min_Inc)
                    r_Min <= (r_Min == 6'd0) ? 6'd59 : r_Min - 6'd1;
                if (w_Hr_Inc && !w_Hr_Dec)
                    r_Hr <= (r_Hr == 5'd23) ? 5'd0 : r_Hr + 5'd1;
                else if (w_Hr_Dec && !w_Hr_Inc)
                    r_Hr <= (r_Hr == 5'd0) ? 5'd23 : r_Hr - 5'd1;
                if (w_Sec_Clr)
                    r_Sec <= 6'd0;
            end else if (i_Clk_1Hz_Pulse && !i_Hold) begin
                if (r_Sec == 6'd59) begin
                    r_Sec         <= 6'd0;
                    r_Minute_Tick <= 1'b1;
                    if (r_Min == 6'd59) begin
                        r_Min       <= 6'd0;
                        r_Hour_Tick <= 1'b1;
                        if (r_Hr == 5'd23) begin
                            r_Hr       <= 5'd0;
                            r_Day_Tick <= 1'b1;
                        end else begin
                            r_Hr <= r_Hr + 5'd1;
                        end
                    end else begin
                        r_Min <= r_Min + 6'd1;
                    end
                end else begin
                    r_Sec <= r_Sec + 6'd1;
                end
            end
        end
    end

    function automatic logic [7:0] f_Bcd(input logic [5:0] i_Val);
        return {4'(i_Val / 6'd10), 4'(i_Val % 6'd10)};
    endfunction

    logic [4:0] w_Hr_Disp;

    always_comb begin
        w_Hr_Disp = r_Hr;
        if (FORMAT_24H == 0) begin
            if (r_Hr == 5'd0)
                w_Hr_Disp = 5'd12;
            else if (r_Hr > 5'd12)
                w_Hr_Disp = r_Hr - 5'd12;
        end
    end

    assign o_Time        = {f_Bcd({1'b0, w_Hr_Disp}), f_Bcd(r_Min), f_Bcd(r_Sec)};
    assign o_PM          = (FORMAT_24H == 0) && (r_Hr >= 5'd12);
    assign o_Minute_Tick = r_Minute_Tick;
    assign o_Hour_Tick   = r_Hour_Tick;
    assign o_Day_Tick    = r_Day_Tick;

endmodule

// File: tb/tb_time_keeper.sv
// Three time_keeper configurations driven in parallel and checked every cycle
// against a seconds-of-day reference model, plus fixed directed expectations.
`timescale 1ns/1ps
module tb_time_keeper;

    logic clk = 1'b0;
    logic rst = 1'b1, tck = 1'b0, hold = 1'b0;
    logic mi = 1'b0, md = 1'b0, hi = 1'b0, hd = 1'b0, sc = 1'b0;

    logic [23:0] dt [3];
    logic        dpm[3], dm[3], dh[3], dd[3];

    always #100 clk = ~clk;

    time_keeper u0 (
        .i_Clk_5MHz(clk), .i_Reset(rst), .i_Clk_1Hz_Pulse(tck), .i_Hold(hold),
        .i_Minutes_Inc(mi), .i_Minutes_Dec(md), .i_Hours_Inc(hi), .i_Hours_Dec(hd),
        .i_Seconds_Clear(sc), .o_Time(dt[0]), .o_PM(dpm[0]),
        .o_Minute_Tick(dm[0]), .o_Hour_Tick(dh[0]), .o_Day_Tick(dd[0]));

    time_keeper #(.FORMAT_24H(1), .START_HOURS(23), .START_MINUTES(59), .START_SECONDS(58)) u1 (
        .i_Clk_5MHz(clk), .i_Reset(rst), .i_Clk_1Hz_Pulse(tck), .i_Hold(hold),
        .i_Minutes_Inc(mi), .i_Minutes_Dec(md), .i_Hours_Inc(hi), .i_Hours_Dec(hd),
        .i_Seconds_Clear(sc), .o_Time(dt[1]), .o_PM(dpm[1]),
        .o_Minute_Tick(dm[1]), .o_Hour_Tick(dh[1]), .o_Day_Tick(dd[1]));

    time_keeper #(.FORMAT_24H(0), .START_HOURS(11), .START_MINUTES(59), .START_SECONDS(59)) u2 (
        .i_Clk_5MHz(clk), .i_Reset(rst), .i_Clk_1Hz_Pulse(tck), .i_Hold(hold),
        .i_Minutes_Inc(mi), .i_Minutes_Dec(md), .i_Hours_Inc(hi), .i_Hours_Dec(hd),
        .i_Seconds_Clear(sc), .o_Time(dt[2]), .o_PM(dpm[2]),
        .o_Minute_Tick(dm[2]), .o_Hour_Tick(dh[2]), .o_Day_Tick(dd[2]));

    // Model: time as seconds since midnight
    int       start_s[3] = '{43200, 86398, 43199};
    int       fmt[3]     = '{0, 1, 0};
    int       mt[3];
    bit [2:0] mk[3];
    bit [4:0] prev;
    int       n_cmp = 0, n_bad = 0;

    function automatic logic [23:0] exp_time(int k);
        int h, m, s;
        h = mt[k] / 3600; m = (mt[k] / 60) % 60; s = mt[k] % 60;
        if (fmt[k] == 0) h = (h % 12 == 0) ? 12 : h % 12;
        return 24'(((h / 10) << 20) | ((h % 10) << 16) | ((m / 10) << 12) |
                   ((m % 10) << 8) | ((s / 10) << 4) | (s % 10));
    endfunction

    task automatic model_step();
        bit [4:0] in, e;
        int h, m, s;
        in = {sc, hd, hi, md, mi};
        if (rst) begin
            for (int k = 0; k < 3; k++) begin mt[k] = start_s[k]; mk[k] = 3'b000; end
            prev = 5'b11111;
            return;
        end
        e = in & ~prev;
        prev = in;
        for (int k = 0; k < 3; k++) begin
            mk[k] = 3'b000;
            if (e != 5'b0) begin
                h = mt[k] / 3600; m = (mt[k] / 60) % 60; s = mt[k] % 60;
                if (e[0] != e[1]) m = (m + (e[0] ? 1 : 59)) % 60;
                if (e[2] != e[3]) h = (h + (e[2] ? 1 : 23)) % 24;
                if (e[4]) s = 0;
                mt[k] = h * 3600 + m * 60 + s;
            end else if (tck && !hold) begin
                mt[k] = (mt[k] + 1) % 86400;
                mk[k] = {mt[k] % 60 == 0, mt[k] % 3600 == 0, mt[k] == 0};
            end
        end
    endtask

    task automatic chk(string name, int k, logic [23:0] act, logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[u%0d] at %0t: got %h, expected %h", name, k, $time, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("time", k, dt[k], exp_time(k));
            chk("pm", k, 24'(dpm[k]), 24'(fmt[k] == 0 && mt[k] >= 43200));
            chk("ticks", k, 24'({dm[k], dh[k], dd[k]}), 24'(mk[k]));
        end
    endtask

    task automatic set_adj(int which, logic v);
        case (which)
            0: mi = v;
            1: md = v;
            2: hi = v;
            3: hd = v;
            default: sc = v;
        endcase
    endtask

    task automatic pulse(int which, int n);
        repeat (n) begin set_adj(which, 1'b1); cycle(); set_adj(which, 1'b0); cycle(); end
    endtask

    task automatic do_reset();
        rst = 1'b1; cycle(); rst = 1'b0; cycle();
    endtask

    initial begin
        // Reset with hours-inc held through release
        hi = 1'b1;
        cycle(); cycle();
        chk("rst_time", 0, dt[0], 24'h120000);
        chk("rst_pm", 0, 24'(dpm[0]), 24'h1);
        chk("rst_ticks", 0, 24'({dm[0], dh[0], dd[0]}), 24'h0);
        chk("rst_time", 2, dt[2], 24'h115959);
        chk("rst_pm", 2, 24'(dpm[2]), 24'h0);
        rst = 1'b0;
        cycle(); cycle(); cycle();
        chk("held_inc", 0, dt[0], 24'h120000);
        hi = 1'b0; cycle();

        // Rollovers
        tck = 1'b1; cycle();
        chk("t1", 1, dt[1], 24'h235959);
        chk("t1", 2, dt[2], 24'h120000);
        chk("t1_pm", 2, 24'(dpm[2]), 24'h1);
        chk("t1_ticks", 2, 24'({dm[2], dh[2], dd[2]}), 24'h6);
        cycle(); tck = 1'b0;
        chk("day", 1, dt[1], 24'h000000);
        chk("day_ticks", 1, 24'({dm[1], dh[1], dd[1]}), 24'h7);
        cycle();
        chk("day_ticks_off", 1, 24'({dm[1], dh[1], dd[1]}), 24'h0);

        do_reset();
        pulse(2, 12);
        chk("23h", 2, dt[2], 24'h115959);
        tck = 1'b1; cycle(); tck = 1'b0;
        chk("midnight", 2, dt[2], 24'h120000);
        chk("midnight_pm", 2, 24'(dpm[2]), 24'h0);
        cycle();

        // Manual adjust
        do_reset();
        pulse(3, 2); pulse(1, 1);
        repeat (30) begin tck = 1'b1; cycle(); tck = 1'b0; cycle(); end
        chk("105930", 0, dt[0], 24'h105930);
        mi = 1'b1; cycle();
        chk("min_wrap", 0, dt[0], 24'h100030);
        chk("min_wrap_ticks", 0, 24'({dm[0], dh[0], dd[0]}), 24'h0);
        mi = 1'b0; cycle();
        pulse(3, 10);
        chk("hr0", 0, dt[0], 24'h120030);
        pulse(3, 1);
        chk("hr23", 0, dt[0], 24'h110030);
        chk("hr23_pm", 0, 24'(dpm[0]), 24'h1);

        mi = 1'b1; repeat (10) cycle(); mi = 1'b0; cycle();
        chk("held_once", 0, dt[0], 24'h110130);
        mi = 1'b1; md = 1'b1; cycle(); mi = 1'b0; md = 1'b0; cycle();
        chk("inc_dec", 0, dt[0], 24'h110130);

        // Tick collisions, hold, reset mid-count
        mi = 1'b1; tck = 1'b1; cycle(); mi = 1'b0; tck = 1'b0;
        chk("adj_wins", 0, dt[0], 24'h110230);
        cycle();
        hold = 1'b1;
        repeat (5) begin tck = 1'b1; cycle(); tck = 1'b0; cycle(); end
        chk("hold", 0, dt[0], 24'h110230);
        hold = 1'b0; tck = 1'b1; cycle(); tck = 1'b0;
        chk("unhold", 0, dt[0], 24'h110231);
        rst = 1'b1; tck = 1'b1; cycle(); rst = 1'b0; tck = 1'b0;
        chk("rst_mid", 0, dt[0], 24'h120000);
        repeat (3) begin tck = 1'b1; cycle(); tck = 1'b0; cycle(); end
        chk("pre_clr", 0, dt[0], 24'h120003);
        pulse(4, 1);
        chk("sec_clr", 0, dt[0], 24'h120000);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(499) == 0);
            tck  = ($urandom_range(2) == 0);
            hold = ($urandom_range(7) == 0);
            if ($urandom_range(5) == 0) mi = ~mi;
            if ($urandom_range(5) == 0) md = ~md;
            if ($urandom_range(5) == 0) hi = ~hi;
            if ($urandom_range(5) == 0) hd = ~hd;
            if ($urandom_range(9) == 0) sc = ~sc;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Parametrised successor to the current 12-hour HH:MM time counter.
- Keeps hours, minutes and seconds, displayable in 12-hour or 24-hour format.
- Supports increment and decrement adjust per field, hold/freeze, and one-cycle rollover pulses for alarm and chime logic.
- Sits between the 1 Hz pulse generator and the BCD display and alarm compare blocks.

Parameters:
FORMAT_24H, 0, 0 = 12-hour display with o_PM; 1 = 24-hour display, o_PM forced 0
START_HOURS, 12, reset hour in internal 0-23 form (12 = noon)
START_MINUTES, 0, reset minute, 0-59
START_SECONDS, 0, reset second, 0-59

Ports:
i_Clk_5MHz  in  1  system clock; all logic on its rising edge
i_Reset  in  1  synchronous, active-high reset
i_Clk_1Hz_Pulse  in  1  one-cycle-wide seconds tick
i_Hold  in  1  level; while 1, ticks are ignored
i_Minutes_Inc  in  1  level; rising edge adds one minute
i_Minutes_Dec  in  1  level; rising edge subtracts one minute
i_Hours_Inc  in  1  level; rising edge adds one hour
i_Hours_Dec  in  1  level; rising edge subtracts one hour
i_Seconds_Clear  in  1  level; rising edge zeroes seconds
o_Time  out  24  BCD HH MM SS: [23:20] hour tens, [19:16] hour ones, [15:12] minute tens, [11:8] minute ones, [7:4] second tens, [3:0] second ones
o_PM  out  1  1 when internal hour >= 12 and FORMAT_24H = 0
o_Minute_Tick  out  1  one-cycle pulse on tick-driven seconds wrap 59->0
o_Hour_Tick  out  1  one-cycle pulse on tick-driven minutes wrap 59->0
o_Day_Tick  out  1  one-cycle pulse on tick-driven wrap 23:59:59 -> 00:00:00

Behaviour:
- Internal state is binary: sec 6b (0-59), min 6b (0-59), hr 5b (0-23), plus one previous-value register per adjust input.
- Reset (synchronous, highest priority):
  - Counters load the START_* values.
  - All tick outputs go to 0.
  - Previous-value registers load 1, so an input held high through reset produces no edge.
- Edge detect: an adjust action fires when the input is 1 and its previous-value register is 0. Previous-value registers sample every cycle.
- Latency: counters and all outputs update on the same clock edge that detects the tick or input edge.
- Priority per cycle, after reset:
  - Any adjust edge (minutes, hours, seconds clear) is applied, and a coincident tick is dropped.
  - Otherwise a tick with i_Hold = 0 advances the time.
- Tick advance:
  - sec+1; at 59, sec becomes 0 and min advances.
  - min at 59 becomes 0 and hr advances.
  - hr at 23 becomes 0.
  - Tick pulses assert for exactly the cycle of the corresponding wrap.
- Manual adjust:
  - Minutes inc wraps 59->0 and dec wraps 0->59, with no carry into hours.
  - Hours inc wraps 23->0 and dec wraps 0->23.
  - Seconds are unchanged except by i_Seconds_Clear.
  - Manual adjust never produces tick pulses.
  - Inc and dec edges on the same field in the same cycle: that field is unchanged.
  - Minute and hour adjusts in the same cycle both apply.
- Display mapping is combinational from the registered counters:
  - 24-hour: hours shown 00-23.
  - 12-hour: hr 0 -> 12 AM; 1-11 -> 1-11 AM; 12 -> 12 PM; 13-23 -> 1-11 PM.
  - In 12-hour mode the hour tens digit is 0 or 1. Leading zero is kept (0x01, not blank).
- START_* values outside their range are unsupported and are not checked by RTL.

Test Plan:
1. Reset with defaults, FORMAT_24H = 0 -> o_Time = 0x120000, o_PM = 1, all ticks 0; release reset while i_Hours_Inc is held 1 -> no hour change.
2. START 23:59:58, FORMAT_24H = 1; apply two ticks -> 0x235959, then 0x000000, with o_Minute_Tick, o_Hour_Tick and o_Day_Tick all high for that one cycle only.
3. START 11:59:59, 12-hour mode; one tick -> 0x120000 and o_PM rises 0->1; from 23:59:59 one tick -> 0x120000 and o_PM = 0.
4. From 10:59:30, pulse i_Minutes_Inc -> 0x100030 with no o_Hour_Tick; pulse i_Hours_Dec at hr 0 -> hr 23 (12-hour display 0x11, o_PM = 1).
5. Hold i_Minutes_Inc high 10 cycles -> exactly one increment; assert i_Minutes_Inc and i_Minutes_Dec edges together -> minutes unchanged.
6. Edge coincident with a tick -> adjust applied and tick dropped (seconds unchanged); with i_Hold = 1, five ticks -> o_Time constant; i_Reset mid-count -> START values on the next edge.
